// File: rtl/traffic_request_arbiter.sv
// Roadside input front end: sync + debounce + latch of raw requests, fixed-priority valid/ack presentation with hold timeout.
// Optional emergency preemption input is enabled by defining TRAFFIC_EMERG_PREEMPT_EN.
module traffic_request_arbiter #(
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int DB_W            = 5,
  parameter int HOLD_TIMEOUT    = 1000,
  parameter int TO_W            = 10
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       ped_btn,
  input  logic       car_ns,
  input  logic       car_ew,
`ifdef TRAFFIC_EMERG_PREEMPT_EN
  input  logic       emerg,
  output logic [3:0] pending,
`else
  output logic [2:0] pending,
`endif
  input  logic       req_ack,
  output logic       req_valid,
  output logic [1:0] req_type,
  output logic       timeout
);

`ifdef TRAFFIC_EMERG_PREEMPT_EN
  localparam int NREQ = 4;
`else
  localparam int NREQ = 3;
`endif

  localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYCLES);
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(HOLD_TIMEOUT - 1);

  typedef enum logic {IDLE, PRESENT} state_t;

  // Bit index equals the request code: 0 NS, 1 EW, 2 ped, 3 emergency.
  logic [NREQ-1:0] raw_in;
  logic [NREQ-1:0] sync1, sync2, filt, filt_d;
  logic [DB_W-1:0] db_cnt [NREQ];
  logic [NREQ-1:0] clr_mask;
  logic [TO_W-1:0] to_cnt;
  logic            served, expire, preempt, no_expiry;
  state_t          state, state_nxt;

`ifdef TRAFFIC_EMERG_PREEMPT_EN
  assign raw_in    = {emerg, ped_btn, car_ew, car_ns};
  assign preempt   = pending[3] && (req_type != 2'b11);
  assign no_expiry = (req_type == 2'b11);
`else
  assign raw_in    = {ped_btn, car_ew, car_ns};
  assign preempt   = 1'b0;
  assign no_expiry = 1'b0;
`endif

  function automatic logic [1:0] pick_type(input logic [NREQ-1:0] p);
    logic [1:0] t;
    t = 2'b01;
    if (p[0]) t = 2'b00;
    if (p[2]) t = 2'b10;
`ifdef TRAFFIC_EMERG_PREEMPT_EN
    if (p[3]) t = 2'b11;
`endif
    return t;
  endfunction

  // The filtered level flips only after the synchronised level has disagreed
  // with it for DEBOUNCE_CYCLES counted cycles plus the terminal check.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1  <= '0;
      sync2  <= '0;
      filt   <= '0;
      filt_d <= '0;
      for (int i = 0; i < NREQ; i++) db_cnt[i] <= '0;
    end else begin
      sync1  <= raw_in;
      sync2  <= sync1;
      filt_d <= filt;
      for (int i = 0; i < NREQ; i++) begin
        if (sync2[i] == filt[i]) begin
          db_cnt[i] <= '0;
        end else if (db_cnt[i] == DB_LAST) begin
          filt[i]   <= sync2[i];
          db_cnt[i] <= '0;
        end else begin
          db_cnt[i] <= db_cnt[i] + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    served    = 1'b0;
    expire    = 1'b0;
    case (state)
      IDLE: begin
        if (|pending) state_nxt = PRESENT;
      end
      PRESENT: begin
        if (req_ack) begin
          served    = 1'b1;
          state_nxt = IDLE;
        end else if (preempt) begin
          state_nxt = IDLE;
        end else if ((to_cnt == TO_LAST) && !no_expiry) begin
          expire    = 1'b1;
          state_nxt = IDLE;
        end
      end
    endcase
  end

  always_comb begin
    req_valid = (state == PRESENT);
  end

  always_comb begin
    clr_mask = '0;
    for (int i = 0; i < NREQ; i++) clr_mask[i] = served && (req_type == 2'(i));
  end

  // A new filtered rising edge in the ack cycle wins over the clear.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      req_type <= 2'b00;
      to_cnt   <= '0;
      timeout  <= 1'b0;
      pending  <= '0;
    end else begin
      timeout <= expire;
      pending <= (pending & ~clr_mask) | (filt & ~filt_d);
      if (state == IDLE) begin
        if (|pending) req_type <= pick_type(pending);
        to_cnt <= '0;
      end else if (to_cnt != TO_LAST) begin
        to_cnt <= to_cnt + 1'b1;
      end
    end
  end

endmodule

// File: doc/traffic_request_arbiter.md
Name: traffic_request_arbiter

Overview:
- Upstream front end for traffic_light_controller.
- Synchronises and debounces raw roadside inputs (pedestrian button, NS and EW vehicle loops) and latches each press/arrival as a pending request.
- Presents one request at a time to the controller over a valid/ack handshake, in fixed priority order.
- Flags a request the controller fails to acknowledge in time.

Parameters:
- DEBOUNCE_CYCLES, 16, consecutive cycles a synchronised input must differ from its filtered level before the filtered level changes (min 2).
- DB_W, 5, debounce counter width; must satisfy 2^DB_W > DEBOUNCE_CYCLES.
- HOLD_TIMEOUT, 1000, cycles a request may sit unacknowledged before timeout (min 2).
- TO_W, 10, timeout counter width; must satisfy 2^TO_W > HOLD_TIMEOUT.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  reset, asynchronous, active-high.
- ped_btn  input  1  raw pedestrian button, asynchronous, active-high.
- car_ns  input  1  raw NS vehicle loop, asynchronous, active-high.
- car_ew  input  1  raw EW vehicle loop, asynchronous, active-high.
- req_ack  input  1  controller accepts the presented request.
- req_valid  output  1  request presented.
- req_type  output  2  request code: 00 NS car, 01 EW car, 10 pedestrian, 11 emergency (macro only).
- pending  output  3  latched requests {ped, ew, ns}.
- timeout  output  1  one-cycle pulse when HOLD_TIMEOUT expires.

Behaviour:
- Reset: one clock; rst is asynchronous and active-high. While rst=1, all of the following clear immediately:
  - req_valid=0, req_type=00, pending=000, timeout=0.
  - Synchroniser flops, filtered levels and all counters = 0.
  - FSM = IDLE.
  - Reset mid-handshake drops the request with no ack required.
- Synchronisation: two-flop synchroniser per raw input.
- Debounce:
  - One counter per input.
  - Counter increments while the synchronised level differs from the filtered level, and clears when they match.
  - When the counter reaches DEBOUNCE_CYCLES, the filtered level toggles and the counter clears.
- Latch: a filtered rising edge sets that input's pending bit on the next edge. Falling edges are ignored.
- Latency: raw high first sampled at edge N gives req_valid=1 after edge N+DEBOUNCE_CYCLES+4 (FSM idle, no other pending).
- FSM states: IDLE and PRESENT.
- IDLE:
  - If pending≠0: load req_type by priority ped > ns > ew, set req_valid=1, clear the timeout counter, go to PRESENT.
  - req_ack is ignored in IDLE.
- PRESENT:
  - req_valid and req_type stay stable.
  - On a cycle with req_ack=1: clear the served pending bit, req_valid=0 next edge, go to IDLE.
  - Otherwise the timeout counter increments. When it reaches HOLD_TIMEOUT: timeout=1 for one cycle, req_valid=0, pending bit retained, go to IDLE. Re-arbitration occurs on the following cycle.
- Minimum gap between two requests: one cycle with req_valid=0.
- Simultaneous set and clear of the same pending bit (new edge in the ack cycle): set wins and the bit stays 1.
- Duplicate edges while a bit is already pending merge into the single pending bit.
- No counter wraps: each saturates/clears at its terminal value.

Optional Feature:
- Macro TRAFFIC_EMERG_PREEMPT_EN.
- Defined:
  - Adds input port emerg (1 bit, raw, asynchronous), synchronised and debounced like the other inputs; pending widens to 4 bits {emerg, ped, ew, ns}.
  - Emergency has top priority; req_type=11.
  - If emergency becomes pending while PRESENT with another type: drop req_valid next edge (the other bit stays pending), return to IDLE, then present emergency.
  - Emergency never times out.
- Undefined: no emerg port, pending is 3 bits, req_type 11 is never produced.

Test Plan (DEBOUNCE_CYCLES=4, HOLD_TIMEOUT=8):
- rst high for 2 cycles mid-PRESENT → all outputs 0 immediately (asynchronous); no req_valid until a new input event.
- ped_btn high for 3 cycles, then low → no pending bit set, req_valid never rises.
- car_ns held high from edge N → req_valid=1, req_type=00 after edge N+8; req_ack 2 cycles later → pending[0]=0, req_valid=0 next edge.
- ped_btn and car_ew debounced on the same cycle → first req_type=10; after ack, one idle cycle, then req_type=01.
- car_ew pending, req_ack held 0 → timeout pulses once after 8 PRESENT cycles; pending[1] stays 1; request re-presented.
- With macro: during PRESENT of type 00, assert emerg → req_valid drops, then req_type=11 is presented; after ack, the NS request is re-presented.
